psdsqrt_seq: RTL and testbench

- Sequencer and wrapper that sits directly around the iterative square-root core (`psdsqrt`).
- Accepts operands on a valid/ready input stream, generates the core's one-cycle `start` and `stop` pulses, and counts the iteration cycles.
- Captures the rounded root and presents it on a valid/ready output stream.
- Saturates the core's 16-bit wrap-around case.

---
 rtl/psdsqrt_seq.sv | 90 +++++++++
 tb/tb_psdsqrt_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/psdsqrt_seq.sv
// psdsqrt_seq: valid/ready sequencer around the iterative psdsqrt core, with output saturation.
// Optional one-entry operand skid buffer enabled by defining PSDSQRT_SEQ_SKID_EN.
module psdsqrt_seq #(
  parameter int NBITSIN = 32,
  parameter int K = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITSIN-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBITSIN/2-1:0] out_data,
  output logic                 busy,
  output logic                 core_start,
  output logic                 core_stop,
  output logic [NBITSIN-1:0]   core_xin,
  input  logic [NBITSIN/2-1:0] core_sqrt
);
  localparam int NITER = (NBITSIN + K) / 2;
  localparam int CW = $clog2(NITER + 1);
  typedef enum logic [2:0] {IDLE, START, ITER, STOP, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [NBITSIN-1:0] op, load_op;
  logic accept, take_in, take_buf, launch;
  assign accept = in_valid && in_ready;
`ifdef PSDSQRT_SEQ_SKID_EN
  logic buf_valid;
  logic [NBITSIN-1:0] buf_data;
  assign in_ready = !buf_valid;
  assign take_buf = buf_valid && (state == IDLE || (state == DONE && out_ready));
  assign take_in = accept && state == IDLE;
  assign load_op = take_buf ? buf_data : in_data;
  // Operands arriving while busy park here; a drain and a fill in one edge keep it full.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_data <= '0;
    end else if (accept && state != IDLE) begin
      buf_valid <= 1'b1;
      buf_data <= in_data;
    end else if (take_buf) begin
      buf_valid <= 1'b0;
    end
`else
  assign in_ready = state == IDLE;
  assign take_buf = 1'b0;
  assign take_in = accept;
  assign load_op = in_data;
`endif
  assign launch = take_in || take_buf;
  assign busy = state != IDLE;
  assign core_start = state == START;
  assign core_stop = state == STOP;
  assign core_xin = op;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = launch ? START : IDLE;
      START: state_nxt = ITER;
      ITER:  state_nxt = cnt == '0 ? STOP : ITER;
      STOP:  state_nxt = WAIT;
      WAIT:  state_nxt = DONE;
      DONE:  state_nxt = out_ready ? (take_buf ? START : IDLE) : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (launch) op <= load_op;
      if (state == START) cnt <= CW'(NITER - 1);
      else if (state == ITER) cnt <= cnt - 1'b1;
      // A zero root from a nonzero operand is the core's rounding wrap past all ones.
      if (state == WAIT) begin
        out_valid <= 1'b1;
        out_data <= (core_sqrt == '0 && op != '0) ? '1 : core_sqrt;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_psdsqrt_seq.sv
// tb_psdsqrt_seq: directed self-checking bench for psdsqrt_seq; the bench plays the core's sqrt output.
module tb_psdsqrt_seq;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy, core_start, core_stop;
  logic [31:0] in_data = '0, core_xin;
  logic [15:0] out_data, core_sqrt = '0;
  int vectors = 0, errors = 0;
  logic [31:0] ops [3];
  int res [$];
  int ai;
  bit acc, busy_acc, seen;
  logic exp_in_ready_done;

  psdsqrt_seq dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .core_start(core_start), .core_stop(core_stop), .core_xin(core_xin), .core_sqrt(core_sqrt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic run_op(input logic [31:0] d, input logic [15:0] root, input logic [15:0] exp, input bit rel);
    int n, ns, np;
    bit ov;
    core_sqrt = root;
    in_data = d;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("core_xin", core_xin, d);
    n = 0; ns = 0; np = 0; ov = 1'b0;
    while (!out_valid && n < 40) begin
      ns += int'(core_start);
      np += int'(core_stop);
      ov |= core_start & core_stop;
      @(posedge clock); #1;
      n++;
    end
    check("latency", n, 23);
    check("start_pulses", ns, 1);
    check("stop_pulses", np, 1);
    check("start_stop_overlap", ov, 1'b0);
    check("out_data", out_data, exp);
    if (rel) release_res();
  endtask

  initial begin
`ifdef PSDSQRT_SEQ_SKID_EN
    exp_in_ready_done = 1'b1;
`else
    exp_in_ready_done = 1'b0;
`endif
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_stop", core_stop, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", in_ready, 1'b1);

    run_op(32'd144, 16'd12, 16'd12, 1'b1);
    run_op(32'd0, 16'd0, 16'd0, 1'b1);
    run_op(32'd3, 16'd2, 16'd2, 1'b1);
    run_op(32'd6, 16'd2, 16'd2, 1'b1);
    run_op(32'd2, 16'd1, 16'd1, 1'b1);
    run_op(32'hFFFF_FFFF, 16'd0, 16'hFFFF, 1'b1);

    run_op(32'd144, 16'd12, 16'd12, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, 16'd12);
      check("hold_in_ready", in_ready, exp_in_ready_done);
    end
    release_res();

    core_sqrt = 16'd9;
    in_data = 32'd81;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #3 reset = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_core_xin", core_xin, 32'd0);
    check("abort_start", core_start, 1'b0);
    check("abort_stop", core_stop, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      seen |= out_valid | core_start | core_stop;
    end
    check("abort_quiet", seen, 1'b0);
    run_op(32'd81, 16'd9, 16'd9, 1'b1);

`ifdef PSDSQRT_SEQ_SKID_EN
    ops[0] = 32'd16; ops[1] = 32'd25; ops[2] = 32'd36;
    ai = 0;
    busy_acc = 1'b0;
    out_ready = 1'b1;
    in_data = ops[0];
    in_valid = 1'b1;
    for (int c = 0; c < 200 && res.size() < 3; c++) begin
      core_sqrt = core_xin == 32'd16 ? 16'd4 : core_xin == 32'd25 ? 16'd5 : core_xin == 32'd36 ? 16'd6 : 16'd0;
      acc = in_valid && in_ready;
      if (acc && ai == 1) busy_acc = busy;
      @(posedge clock); #1;
      if (acc) begin
        ai++;
        if (ai < 3) in_data = ops[ai];
        else in_valid = 1'b0;
      end
      if (out_valid) res.push_back(int'(out_data));
    end
    out_ready = 1'b0;
    check("skid_count", res.size(), 3);
    check("skid_res0", res.size() > 0 ? res[0] : -1, 4);
    check("skid_res1", res.size() > 1 ? res[1] : -1, 5);
    check("skid_res2", res.size() > 2 ? res[2] : -1, 6);
    check("skid_busy_accept", busy_acc, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
